// File: rtl/gate_test_sequencer.sv
// Purpose: drives the four {a,b} combinations into a 2-input gate, samples its output after SETTLE cycles and scores it against a truth table.
// Latency: a run takes 4*(SETTLE+1) edges from accepted start to the done cycle; IDLE again one edge after done.
// Backpressure: none; start is only looked at in IDLE, so requests while busy or finishing are dropped.
// Optional feature: define GATE_SEQ_FAIL_CAPTURE_EN to add fail_valid/fail_vec (first mismatching vector).
module gate_test_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  output logic       fail_valid,
  output logic [1:0] fail_vec,
`endif
  output logic [2:0] err_count
);

  // SETTLE must fit the 4-bit settle counter and be at least one cycle
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("gate_test_sequencer: SETTLE must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_n;
  logic [1:0] vec_q, vec_n;
  logic [3:0] cnt_q, cnt_n;
  logic [3:0] exp_q, exp_n;
  logic [2:0] err_q, err_n;
  logic       pass_q, pass_n;
  logic       done_q, done_n;
  logic       mismatch;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  logic       fvld_q, fvld_n;
  logic [1:0] fvec_q, fvec_n;
`endif

  // The gate output is scored against the table latched at start, never the live input
  assign mismatch = (gate_c != exp_q[vec_q]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // Next-state and datapath updates; defaults hold every register
  always_comb begin
    state_n = state_q;
    vec_n   = vec_q;
    cnt_n   = cnt_q;
    exp_n   = exp_q;
    err_n   = err_q;
    pass_n  = pass_q;
    done_n  = 1'b0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    fvld_n  = fvld_q;
    fvec_n  = fvec_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_n   = expected;
          vec_n   = 2'd0;
          cnt_n   = 4'd0;
          err_n   = 3'd0;
          pass_n  = 1'b0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
          fvld_n  = 1'b0;
          fvec_n  = 2'd0;
`endif
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_n = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_n = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // At most four increments, so the 3-bit count never wraps
        if (mismatch) begin
          err_n = err_q + 3'd1;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
          if (!fvld_q) begin
            fvld_n = 1'b1;
            fvec_n = vec_q;
          end
`endif
        end
        if (vec_q == 2'd3) begin
          // vec stays at 3 so the gate inputs rest at 2'b11 until the next start
          done_n  = 1'b1;
          pass_n  = (err_n == 3'd0);
          state_n = ST_FINISH;
        end else begin
          vec_n   = vec_q + 2'd1;
          cnt_n   = 4'd0;
          state_n = ST_WAIT;
        end
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath registers; reset aborts a run and suppresses done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= 2'd0;
      cnt_q  <= 4'd0;
      exp_q  <= 4'd0;
      err_q  <= 3'd0;
      pass_q <= 1'b0;
      done_q <= 1'b0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
      fvld_q <= 1'b0;
      fvec_q <= 2'd0;
`endif
    end else begin
      vec_q  <= vec_n;
      cnt_q  <= cnt_n;
      exp_q  <= exp_n;
      err_q  <= err_n;
      pass_q <= pass_n;
      done_q <= done_n;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
      fvld_q <= fvld_n;
      fvec_q <= fvec_n;
`endif
    end
  end

  assign gate_a    = vec_q[1];
  assign gate_b    = vec_q[0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  assign fail_valid = fvld_q;
  assign fail_vec   = fvec_q;
`endif

endmodule
